// File: rtl/round_robin_dispatch.sv
// Round-robin dispatcher: spreads one valid/ready input stream across WIDTH
// output channels, each accepted word going to the next enabled channel after
// the previous target. One-word registered output stage, 1 word/clk sustained.
module round_robin_dispatch #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned WIDTH_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [WIDTH-1:0]   ch_en,
    input  logic               s_valid,
    input  logic [DATA_W-1:0]  s_data,
    output logic               s_ready,
    output logic [WIDTH-1:0]   m_valid,
    output logic [DATA_W-1:0]  m_data,
    output logic [WIDTH_W-1:0] m_sel,
    input  logic [WIDTH-1:0]   m_ready,
    output logic               busy
);

    localparam logic [WIDTH_W-1:0] LAST_IDX = WIDTH_W'(WIDTH - 1);

    logic               full_q,    full_d;
    logic [DATA_W-1:0]  m_data_q,  m_data_d;
    logic [WIDTH_W-1:0] m_sel_q,   m_sel_d;
    logic [WIDTH-1:0]   m_valid_q, m_valid_d;
    logic [WIDTH_W-1:0] ptr_q,     ptr_d;

    logic [WIDTH_W-1:0] tgt;
    logic [WIDTH_W-1:0] idx;
    logic               found;
    logic               none_en;
    logic               drain;
    logic               load;

    // Find the first enabled channel at or after ptr, wrapping explicitly so
    // non-power-of-two WIDTH never produces an out-of-range index.
    always_comb begin
        tgt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (32'(ptr_q) + i >= WIDTH) begin
                idx = WIDTH_W'(32'(ptr_q) + i - WIDTH);
            end else begin
                idx = WIDTH_W'(32'(ptr_q) + i);
            end
            if (!found && ch_en[idx]) begin
                found = 1'b1;
                tgt   = idx;
            end
        end
    end

    assign none_en = ~|ch_en;
    // Only the ready of the channel holding the word matters.
    assign drain   = full_q & m_ready[m_sel_q];
    assign s_ready = nrst & ~none_en & (~full_q | drain);
    assign load    = s_valid & s_ready;

    // Next-state: a load overwrites the buffer (covers same-cycle drain+load),
    // a lone drain only clears the full flag and leaves data/sel/ptr alone.
    always_comb begin
        full_d    = full_q;
        m_data_d  = m_data_q;
        m_sel_d   = m_sel_q;
        m_valid_d = m_valid_q;
        ptr_d     = ptr_q;
        if (load) begin
            full_d         = 1'b1;
            m_data_d       = s_data;
            m_sel_d        = tgt;
            m_valid_d      = '0;
            m_valid_d[tgt] = 1'b1;
            ptr_d          = (tgt == LAST_IDX) ? '0 : tgt + 1'b1;
        end else if (drain) begin
            full_d    = 1'b0;
            m_valid_d = '0;
        end
    end

    // State registers with synchronous active-low reset; reset drops any held word.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            full_q    <= 1'b0;
            m_data_q  <= '0;
            m_sel_q   <= '0;
            m_valid_q <= '0;
            ptr_q     <= '0;
        end else begin
            full_q    <= full_d;
            m_data_q  <= m_data_d;
            m_sel_q   <= m_sel_d;
            m_valid_q <= m_valid_d;
            ptr_q     <= ptr_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_sel   = m_sel_q;
    assign busy    = full_q;

endmodule
